uart_tx: RTL
============

# uart_tx

Serial UART transmitter, the transmit-side counterpart of the team's UART receiver. Accepts one byte at a time over a valid/ready handshake and shifts it out on `tx` as a standard asynchronous frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. The bit period comes from an integer clock-to-baud divider, computed the same way as the rest of the codebase's `clk_mhz`-based timing generators. The block sits between the byte-producing logic and the board TX pin.

## Interface
- `clk_mhz`, 50, system clock frequency in MHz.
- `baud`, 115200, line rate in bits/s.
- `parity`, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- `stop_bits`, 1, number of stop bits: 1 or 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `data`  in  8  byte to send; sampled only on acceptance.
- `valid`  in  1  source has a byte on `data`.
- `ready`  out  1  block can accept a byte this cycle.
- `tx`  out  1  serial line output; idle high.
- `busy`  out  1  frame in progress.

## Operation
- Bit period: `div = clk_mhz*1_000_000/baud`, truncated (434 at defaults). Baud counter width is `$clog2(div)`. `div < 2` is a configuration error and is not supported.
- FSM states and behaviour:
  - IDLE: `tx`=1, `ready`=1, `busy`=0.
  - START: `tx`=0.
  - DATA: `tx` = shift register bit 0. The shift register shifts right at the end of each bit. A 3-bit index counts 0..7.
  - PARITY: only visited when `parity`≠0. `tx` = XOR of the latched byte for even, inverted XOR for odd.
  - STOP: `tx`=1. Lasts `stop_bits` bit periods.
- Transitions:
  - IDLE→START on `valid && ready`. On that edge, `data` is latched into the shift register and the parity accumulator.
  - START→DATA after `div` cycles.
  - DATA→PARITY (or STOP if `parity`=0) after the 8th bit's `div` cycles.
  - PARITY→STOP after `div` cycles.
  - STOP→IDLE after `stop_bits*div` cycles.
- Handshake:
  - `ready` is high only in IDLE.
  - `valid` without `ready` is ignored. The source holds `data`/`valid` until accepted.
  - `data` changes after acceptance do not affect the frame in flight.
- `busy` = 1 in every state except IDLE.
- `tx`, `ready` and `busy` are registered outputs. There is no combinational path from inputs to outputs.

## Timing
- Reset values while `rst_n`=0: `tx`=1, `ready`=1, `busy`=0, state IDLE, all counters and the shift register 0.
- Reset mid-frame: `tx` goes high asynchronously, the frame is abandoned, and no partial byte is resumed.
- Acceptance edge T: `tx` falls and `busy` rises at T+1. `ready` falls at T+1.
- Every bit, including each stop bit, is exactly `div` cycles. The baud counter reloads at every bit boundary.
- The frame ends with `ready`=1 in the cycle after the last stop-bit cycle.
- Back-to-back transfers with `valid` held high: the next acceptance happens in that first IDLE cycle. The line therefore stays high for `stop_bits*div + 1` cycles between frames.
- Minimum frame-to-frame period is `(1+8+P+stop_bits)*div + 1` cycles, where P = 1 if parity is enabled, else 0.

## Test plan
- Test parameters for all scenarios: `clk_mhz`=1, `baud`=100000, so `div`=10.
- 8N1, send 0x55 -> `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 10 cycles. `tx` falls 1 cycle after acceptance. `ready` returns 100 cycles after `tx` falls.
- Even parity, send 0x07 -> parity bit 1. Odd parity, send 0x07 -> parity bit 0. Frame is 110 cycles.
- `stop_bits`=2, `valid` held high with 0xA5 then 0x3C -> each byte decodes correctly LSB first. The high gap between the last data/parity bit and the next start bit is 21 cycles.
- `valid` pulsed for 1 cycle mid-frame with 0xFF -> ignored. `data` changed mid-frame -> the current frame is unaffected.
- `rst_n` asserted during data bit 3 -> `tx`=1 immediately, `busy`=0, `ready`=1. After release, sending 0x81 produces a clean frame.
- Self-check: loop `tx` into the team's UART receiver at matching `baud` and send 0x00..0xFF -> all 256 bytes received in order with no framing errors.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte input, asynchronous serial frame output.
// Frame: start, 8 data bits LSB first, optional parity, 1 or 2 stops.
module uart_tx #(
   parameter int clk_mhz   = 50,
   parameter int baud      = 115200,
   parameter int parity    = 0,
   parameter int stop_bits = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   localparam int DIV = (clk_mhz * 1_000_000) / baud;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam bit PAR_EN   = (parity != 0);
   localparam bit PAR_ODD  = (parity == 2);
   localparam bit TWO_STOP = (stop_bits == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          stop_q, stop_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          tx_q, tx_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          accept;
   logic          bit_end;

   assign accept  = valid && ready_q;
   assign bit_end = (cnt_q == LAST);

   assign tx    = tx_q;
   assign ready = ready_q;
   assign busy  = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      // Counter reloads at every bit boundary and rests at zero in idle.
      if (state_q == S_IDLE || bit_end) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_START;
               shift_d = data;
               par_d   = ^data;
               idx_d   = '0;
               stop_d  = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 1'b1;
               if (idx_q == 3'd7) begin
                  state_d = PAR_EN ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (!TWO_STOP || stop_q) begin
                  state_d = S_IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs follow the next state so they change on the same edge.
   always_comb begin
      tx_d    = 1'b1;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      unique case (state_d)
         S_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         S_START: begin
            tx_d = 1'b0;
         end
         S_DATA: begin
            tx_d = shift_d[0];
         end
         S_PARITY: begin
            tx_d = par_q ^ PAR_ODD;
         end
         S_STOP: begin
            tx_d = 1'b1;
         end
         default: begin
            tx_d = 1'b1;
         end
      endcase
   end

endmodule
